// File: rtl/mem_stage.sv
// MEM pipeline stage: bus master for aligned loads/stores, misalignment
// detection and the MEM/WB pipeline register.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] ex_pc,
  input  logic        ex_en,
  input  logic        ex_br_flag,
  input  logic [1:0]  ex_ctrl_op,
  input  logic [4:0]  ex_dst_addr,
  input  logic        ex_gpr_we_,
  input  logic [2:0]  ex_exp_code,
  input  logic [1:0]  ex_mem_op,
  input  logic [31:0] ex_mem_wr_data,
  input  logic [31:0] ex_out,
  input  logic        stall,
  input  logic        flush,
  output logic        busy,
  output logic        bus_req_,
  input  logic        bus_grant_,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_,
  output logic [29:0] mem_pc,
  output logic        mem_en,
  output logic        mem_br_flag,
  output logic [1:0]  mem_ctrl_op,
  output logic [4:0]  mem_dst_addr,
  output logic        mem_gpr_we_,
  output logic [2:0]  mem_exp_code,
  output logic [31:0] mem_out,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] OP_LOAD        = 2'd1;
  localparam logic [1:0] OP_STORE       = 2'd2;
  localparam logic [2:0] EXP_MISS_ALIGN = 3'd4;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACCESS = 2'd2, STALL = 2'd3} state_t;

  state_t      state, state_nxt;
  logic        req_nxt, as_nxt, rw_nxt;
  logic [29:0] addr_nxt;
  logic [31:0] wd_nxt, rd_buf, rd_buf_nxt, rd_data, mem_data;
  logic        is_mem, access, miss_align;

  assign is_mem     = (ex_mem_op == OP_LOAD) || (ex_mem_op == OP_STORE);
  assign access     = ex_en && is_mem && (ex_out[1:0] == 2'b00);
  assign miss_align = ex_en && is_mem && (ex_out[1:0] != 2'b00);
  assign mem_data   = (access && ex_mem_op == OP_LOAD) ? rd_data : ex_out;
  assign dbg_state  = state;

  // Bus handshake: bus_req_ low from REQ until the cycle after bus_rdy_ is seen
  // low; bus_grant_ low in REQ starts the transfer; bus_as_ strobes low for the
  // first ACCESS cycle only; bus_rdy_ low in ACCESS ends it (read data valid then).
  always_comb begin
    state_nxt  = state;
    req_nxt    = bus_req_;
    as_nxt     = 1'b1;
    rw_nxt     = bus_rw;
    addr_nxt   = bus_addr;
    wd_nxt     = bus_wr_data;
    rd_buf_nxt = rd_buf;
    busy       = 1'b0;
    rd_data    = 32'h0;
    case (state)
      IDLE: begin
        if (access && !flush) begin
          req_nxt   = 1'b0;
          busy      = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        busy = 1'b1;
        if (!bus_grant_) begin
          as_nxt    = 1'b0;
          addr_nxt  = ex_out[31:2];
          rw_nxt    = (ex_mem_op == OP_LOAD);
          wd_nxt    = ex_mem_wr_data;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (!bus_rdy_) begin
          req_nxt    = 1'b1;
          rd_buf_nxt = bus_rd_data;
          rd_data    = bus_rd_data;
          state_nxt  = stall ? STALL : IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      STALL: begin
        rd_data = rd_buf;
        if (!stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bus_req_    <= 1'b1;
      bus_as_     <= 1'b1;
      bus_rw      <= 1'b1;
      bus_addr    <= 30'h0;
      bus_wr_data <= 32'h0;
      rd_buf      <= 32'h0;
    end else begin
      state       <= state_nxt;
      bus_req_    <= req_nxt;
      bus_as_     <= as_nxt;
      bus_rw      <= rw_nxt;
      bus_addr    <= addr_nxt;
      bus_wr_data <= wd_nxt;
      rd_buf      <= rd_buf_nxt;
    end
  end

  // MEM/WB register; flush only takes effect when the pipeline advances.
  always_ff @(posedge clk) begin
    if (reset || (!stall && flush)) begin
      mem_pc       <= 30'h0;
      mem_en       <= 1'b0;
      mem_br_flag  <= 1'b0;
      mem_ctrl_op  <= 2'h0;
      mem_dst_addr <= 5'h0;
      mem_gpr_we_  <= 1'b1;
      mem_exp_code <= 3'h0;
      mem_out      <= 32'h0;
    end else if (!stall) begin
      mem_pc       <= ex_pc;
      mem_en       <= ex_en;
      mem_br_flag  <= ex_br_flag;
      mem_dst_addr <= ex_dst_addr;
      if (miss_align) begin
        mem_ctrl_op  <= 2'h0;
        mem_gpr_we_  <= 1'b1;
        mem_exp_code <= EXP_MISS_ALIGN;
        mem_out      <= 32'h0;
      end else begin
        mem_ctrl_op  <= ex_ctrl_op;
        mem_gpr_we_  <= ex_gpr_we_;
        mem_exp_code <= ex_exp_code;
        mem_out      <= mem_data;
      end
    end
  end

endmodule
